// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator with registered, mutually aligned outputs.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int       H_SYNC   = 120,
    parameter int       H_BACK   = 64,
    parameter int       H_ACTIVE = 800,
    parameter int       H_FRONT  = 56,
    parameter int       V_SYNC   = 6,
    parameter int       V_BACK   = 23,
    parameter int       V_ACTIVE = 600,
    parameter int       V_FRONT  = 37,
    parameter logic     H_POL    = 1'b0,
    parameter logic     V_POL    = 1'b0,
    parameter int       ADDR_W   = 11
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              PixEn_Sig,
    output logic              HSYNC_Sig,
    output logic              VSYNC_Sig,
    output logic              Ready_Sig,
    output logic [ADDR_W-1:0] Column_Addr_Sig,
    output logic [ADDR_W-1:0] Row_Addr_Sig,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic              Frame_Start_Sig,
    output logic [15:0]       Frame_Cnt_Sig
`else
    output logic              Frame_Start_Sig
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [ADDR_W-1:0] H_LAST     = ADDR_W'(H_TOTAL - 1);
    localparam logic [ADDR_W-1:0] V_LAST     = ADDR_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] H_SYNC_END = ADDR_W'(H_SYNC);
    localparam logic [ADDR_W-1:0] V_SYNC_END = ADDR_W'(V_SYNC);
    localparam logic [ADDR_W-1:0] H_ACT_LO   = ADDR_W'(H_SYNC + H_BACK);
    localparam logic [ADDR_W-1:0] H_ACT_HI   = ADDR_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_ACT_LO   = ADDR_W'(V_SYNC + V_BACK);
    localparam logic [ADDR_W-1:0] V_ACT_HI   = ADDR_W'(V_SYNC + V_BACK + V_ACTIVE);

    logic [ADDR_W-1:0] h_cnt;
    logic [ADDR_W-1:0] v_cnt;

    logic              hsync_d;
    logic              vsync_d;
    logic              active_d;
    logic [ADDR_W-1:0] col_d;
    logic [ADDR_W-1:0] row_d;
    logic              frame_d;

    // Decode of the current counter position; registered on the next tick.
    always_comb begin
        hsync_d  = (h_cnt < H_SYNC_END) ? H_POL : ~H_POL;
        vsync_d  = (v_cnt < V_SYNC_END) ? V_POL : ~V_POL;
        active_d = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI) &&
                   (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
        col_d    = '0;
        row_d    = '0;
        if (active_d) begin
            col_d = h_cnt - H_ACT_LO;
            row_d = v_cnt - V_ACT_LO;
        end
        frame_d  = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            HSYNC_Sig       <= ~H_POL;
            VSYNC_Sig       <= ~V_POL;
            Ready_Sig       <= 1'b0;
            Column_Addr_Sig <= '0;
            Row_Addr_Sig    <= '0;
            Frame_Start_Sig <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            Frame_Cnt_Sig   <= '0;
`endif
        end else if (PixEn_Sig) begin
            HSYNC_Sig       <= hsync_d;
            VSYNC_Sig       <= vsync_d;
            Ready_Sig       <= active_d;
            Column_Addr_Sig <= col_d;
            Row_Addr_Sig    <= row_d;
            Frame_Start_Sig <= frame_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (frame_d) begin
                Frame_Cnt_Sig <= Frame_Cnt_Sig + 16'd1;
            end
`endif
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end else begin
            // Strobe stays one CLK wide even when ticks are sparse.
            Frame_Start_Sig <= 1'b0;
        end
    end

endmodule
